// File: rtl/pspin_rx_pkt_alloc_if.sv
// Handshake bundle between the matching engine, the ingress DMA, PsPIN's packet-completion path and the allocator.
// The allocator connects to the slave modport. Testbenches and neighbouring blocks connect to the master modport.
interface pspin_rx_pkt_alloc_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned LEN_WIDTH  = 20,
   parameter int unsigned TAG_WIDTH  = 8
);
   logic [LEN_WIDTH-1:0]  s_alloc_len;
   logic [TAG_WIDTH-1:0]  s_alloc_tag;
   logic                  s_alloc_valid;
   logic                  s_alloc_ready;

   logic [ADDR_WIDTH-1:0] m_write_desc_addr;
   logic [LEN_WIDTH-1:0]  m_write_desc_len;
   logic [TAG_WIDTH-1:0]  m_write_desc_tag;
   logic                  m_write_desc_valid;
   logic                  m_write_desc_ready;

   logic [ADDR_WIDTH-1:0] s_free_addr;
   logic                  s_free_valid;
   logic                  s_free_ready;

   modport master (
      output s_alloc_len, s_alloc_tag, s_alloc_valid,
      input  s_alloc_ready,
      input  m_write_desc_addr, m_write_desc_len, m_write_desc_tag, m_write_desc_valid,
      output m_write_desc_ready,
      output s_free_addr, s_free_valid,
      input  s_free_ready
   );

   modport slave (
      input  s_alloc_len, s_alloc_tag, s_alloc_valid,
      output s_alloc_ready,
      output m_write_desc_addr, m_write_desc_len, m_write_desc_tag, m_write_desc_valid,
      input  m_write_desc_ready,
      input  s_free_addr, s_free_valid,
      output s_free_ready
   );
endinterface

// File: rtl/pspin_rx_pkt_alloc.sv
// Ring-buffer allocator for PsPIN packet memory. It carves ALIGN-rounded regions and issues an ingress DMA write descriptor for each one.
// Regions are reclaimed in allocation order. The bytes skipped at the end of the ring when an allocation wraps are charged to that allocation.
module pspin_rx_pkt_alloc #(
   parameter int unsigned           ADDR_WIDTH   = 32,
   parameter int unsigned           LEN_WIDTH    = 20,
   parameter int unsigned           TAG_WIDTH    = 8,
   parameter logic [ADDR_WIDTH-1:0] BUF_START    = 32'h1C40_0000,
   parameter int unsigned           BUF_SIZE     = 32'h0004_0000,
   parameter int unsigned           ALIGN        = 64,
   parameter int unsigned           MAX_INFLIGHT = 32
) (
   input  logic                            clk,
   input  logic                            rstn,
   pspin_rx_pkt_alloc_if.slave             bus,
   output logic [31:0]                     used_bytes,
   output logic [$clog2(MAX_INFLIGHT):0]   inflight_cnt,
   output logic                            err_free,
   output logic                            err_len
);

   localparam int unsigned PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
   localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT) + 1;
   localparam int unsigned SZ_W  = 34;
   localparam logic [SZ_W-1:0]      SIZE_X   = SZ_W'(BUF_SIZE);
   localparam logic [LEN_WIDTH:0]   ALIGN_M1 = (LEN_WIDTH+1)'(ALIGN - 1);

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [31:0]           cost;
   } entry_t;

   entry_t fifo_mem [MAX_INFLIGHT];

   logic [31:0]           wr_off_q, wr_off_d;
   logic [31:0]           used_q, used_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  desc_valid_q, desc_valid_d;
   logic [ADDR_WIDTH-1:0] desc_addr_q, desc_addr_d;
   logic [LEN_WIDTH-1:0]  desc_len_q, desc_len_d;
   logic [TAG_WIDTH-1:0]  desc_tag_q, desc_tag_d;
   logic                  err_free_q, err_free_d;
   logic                  err_len_q, err_len_d;
   logic                  free_ready_q;

   logic [LEN_WIDTH:0]    round_len;
   logic [SZ_W-1:0]       r_ext, wr_ext, end_ext, alloc_cost, used_ext;
   logic [ADDR_WIDTH-1:0] alloc_addr;
   logic [31:0]           next_off;
   logic                  len_bad, room, desc_free, alloc_hs, accept, free_hs, free_hit;
   entry_t                head;

   // NOTE: every signal gets a default at the top of the block so no path can leave one unassigned and infer a latch.
   always_comb begin
      // All arithmetic runs at 34 bits, so the sum of two ring-sized quantities cannot wrap around.
      round_len = ({1'b0, bus.s_alloc_len} + ALIGN_M1) & ~ALIGN_M1;
      r_ext     = SZ_W'(round_len);
      wr_ext    = SZ_W'(wr_off_q);
      end_ext   = wr_ext + r_ext;
      used_ext  = SZ_W'(used_q);
      len_bad   = (bus.s_alloc_len == '0) || (r_ext > SIZE_X);

      if (end_ext <= SIZE_X) begin
         alloc_addr = BUF_START + ADDR_WIDTH'(wr_off_q);
         alloc_cost = r_ext;
         next_off   = (end_ext == SIZE_X) ? '0 : end_ext[31:0];
      end else begin
         alloc_addr = BUF_START;
         alloc_cost = SIZE_X - wr_ext + r_ext;
         next_off   = r_ext[31:0];
      end

      room      = (used_ext + alloc_cost <= SIZE_X) && (cnt_q < CNT_W'(MAX_INFLIGHT));
      desc_free = !desc_valid_q || bus.m_write_desc_ready;
      // A bad length is swallowed whenever the descriptor slot is free, even when the ring is full.
      bus.s_alloc_ready = rstn && desc_free && (len_bad || room);

      alloc_hs = bus.s_alloc_valid && bus.s_alloc_ready;
      accept   = alloc_hs && !len_bad;
      head     = fifo_mem[rd_ptr_q];
      free_hs  = bus.s_free_valid && free_ready_q;
      free_hit = free_hs && (cnt_q != '0) && (bus.s_free_addr == head.addr);

      wr_off_d     = wr_off_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      cnt_d        = cnt_q;
      desc_valid_d = desc_valid_q;
      desc_addr_d  = desc_addr_q;
      desc_len_d   = desc_len_q;
      desc_tag_d   = desc_tag_q;
      err_free_d   = err_free_q || (free_hs && !free_hit);
      err_len_d    = alloc_hs && len_bad;
      used_d       = 32'(used_ext + (accept ? alloc_cost : '0) - (free_hit ? SZ_W'(head.cost) : '0));

      if (desc_valid_q && bus.m_write_desc_ready) desc_valid_d = 1'b0;
      if (accept) begin
         desc_valid_d = 1'b1;
         desc_addr_d  = alloc_addr;
         desc_len_d   = bus.s_alloc_len;
         desc_tag_d   = bus.s_alloc_tag;
         wr_off_d     = next_off;
         wr_ptr_d     = wr_ptr_q + 1'b1;
      end
      if (free_hit) rd_ptr_d = rd_ptr_q + 1'b1;
      if (accept && !free_hit)      cnt_d = cnt_q + 1'b1;
      else if (!accept && free_hit) cnt_d = cnt_q - 1'b1;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of process order.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_off_q     <= '0;
         used_q       <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         cnt_q        <= '0;
         desc_valid_q <= 1'b0;
         desc_addr_q  <= '0;
         desc_len_q   <= '0;
         desc_tag_q   <= '0;
         err_free_q   <= 1'b0;
         err_len_q    <= 1'b0;
         free_ready_q <= 1'b1;
      end else begin
         wr_off_q     <= wr_off_d;
         used_q       <= used_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         cnt_q        <= cnt_d;
         desc_valid_q <= desc_valid_d;
         desc_addr_q  <= desc_addr_d;
         desc_len_q   <= desc_len_d;
         desc_tag_q   <= desc_tag_d;
         err_free_q   <= err_free_d;
         err_len_q    <= err_len_d;
         free_ready_q <= 1'b1;
      end
   end

   // NOTE: the FIFO storage has no reset. The pointers and count decide which entries are live, so stale contents are never read.
   always_ff @(posedge clk) begin
      if (accept) fifo_mem[wr_ptr_q] <= '{addr: alloc_addr, cost: alloc_cost[31:0]};
   end

   assign bus.m_write_desc_valid = desc_valid_q;
   assign bus.m_write_desc_addr  = desc_addr_q;
   assign bus.m_write_desc_len   = desc_len_q;
   assign bus.m_write_desc_tag   = desc_tag_q;
   assign bus.s_free_ready       = free_ready_q;
   assign used_bytes             = used_q;
   assign inflight_cnt           = cnt_q;
   assign err_free               = err_free_q;
   assign err_len                = err_len_q;

endmodule

// File: doc/pspin_rx_pkt_alloc.md
# pspin_rx_pkt_alloc

Packet-buffer allocator that sits directly upstream of the PsPIN ingress DMA engine. It accepts one length request per matched frame and carves an aligned region out of a ring buffer in PsPIN packet memory. It issues the write descriptor (addr, len, tag) to the ingress DMA and reclaims space when PsPIN returns completed packets in allocation order.

## Interface
- ADDR_WIDTH, 32: PsPIN packet-memory address width.
- LEN_WIDTH, 20: frame length width (bytes).
- TAG_WIDTH, 8: request tag width.
- BUF_START, 32'h1C40_0000: base address of the ring; must be ALIGN-aligned.
- BUF_SIZE, 32'h0004_0000: ring size in bytes; must be a multiple of ALIGN.
- ALIGN, 64: allocation granularity in bytes; must be a power of two. Equals one AXI beat.
- MAX_INFLIGHT, 32: depth of the outstanding-allocation FIFO; must be a power of two.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset: synchronous, active-low.
- s_alloc_len  in  LEN_WIDTH  frame length in bytes, from the matching engine.
- s_alloc_tag  in  TAG_WIDTH  frame tag.
- s_alloc_valid  in  1  request valid.
- s_alloc_ready  out  1  request accepted when high together with valid.
- m_write_desc_addr  out  ADDR_WIDTH  allocated start address, to the ingress DMA.
- m_write_desc_len  out  LEN_WIDTH  unrounded s_alloc_len.
- m_write_desc_tag  out  TAG_WIDTH  s_alloc_tag.
- m_write_desc_valid / m_write_desc_ready  out/in  1  descriptor handshake.
- s_free_addr  in  ADDR_WIDTH  start address of the completed packet.
- s_free_valid / s_free_ready  in/out  1  free handshake; s_free_ready is constant 1 out of reset.
- used_bytes  out  32  bytes currently reserved, including wrap slack.
- inflight_cnt  out  $clog2(MAX_INFLIGHT)+1  outstanding allocations.
- err_free  out  1  sticky; set on an invalid free.
- err_len  out  1  one-cycle pulse on an invalid request length.

## Operation
- State:
  - wr_off: byte offset of the next free position, range 0..BUF_SIZE-1.
  - used: byte counter.
  - Inflight FIFO of {addr, cost}.
  - Output descriptor register.
- Rounding: R = (len + ALIGN-1) & ~(ALIGN-1), computed at LEN_WIDTH+1 bits with no overflow.
- Fit case, wr_off + R <= BUF_SIZE:
  - addr = BUF_START + wr_off, cost = R.
  - wr_off' = wr_off + R, with BUF_SIZE mapping to 0.
- Wrap case, wr_off + R > BUF_SIZE:
  - addr = BUF_START, cost = (BUF_SIZE - wr_off) + R.
  - wr_off' = R. The tail slack is charged to this allocation.
- s_alloc_ready is high only when all of the following hold:
  - rstn is high.
  - (!m_write_desc_valid || m_write_desc_ready).
  - used + cost <= BUF_SIZE, using the pre-update used value; a same-cycle free does not count.
  - inflight_cnt < MAX_INFLIGHT.
- s_alloc_ready depends combinationally on s_alloc_len. It never depends on s_alloc_valid.
- Invalid length: len == 0 or R > BUF_SIZE.
  - s_alloc_ready is high (output register free), so the request is consumed.
  - err_len pulses; no descriptor, no FIFO push, no state change.
- Accept:
  - Load the descriptor register and set m_write_desc_valid.
  - Push {addr, cost}; update used and wr_off.
- Free handshake:
  - FIFO non-empty and s_free_addr == head.addr: pop the head and reduce used by head.cost.
  - FIFO empty or address mismatch: set err_free; FIFO and used unchanged.
- Simultaneous accept and valid free: used' = used + cost - head.cost. Push and pop happen in the same cycle and inflight_cnt is unchanged.
- err_free clears only on reset.

## Timing
- Reset values:
  - All outputs 0, except s_free_ready = 1 after the first reset cycle.
  - wr_off = 0, used = 0, FIFO empty.
- Reset mid-operation discards all outstanding allocations and any pending descriptor. The next descriptor is BUF_START.
- Latency: request handshake in cycle N -> m_write_desc_valid high in N+1.
- Throughput: one request per cycle while m_write_desc_ready stays high.
- Descriptor fields are stable while valid && !ready. The descriptor drops the cycle after the handshake unless a new request is accepted in the same cycle.
- Free is applied in the handshake cycle; used_bytes reflects it in N+1.
- A freed region is allocatable from cycle N+1.

## Test plan
- Basic allocation: BUF_SIZE 4096, alloc len 1500 tag 5.
  - Descriptor: addr BUF_START, len 1500, tag 5, one cycle after accept.
  - used_bytes 1536; next request's addr is BUF_START+0x600.
- Wrap: alloc A 1536 and B 1536, free A, then alloc C len 1500.
  - C: addr BUF_START, cost 2560.
  - used_bytes 4096, wr_off 1536.
- Full stall: from the wrap state, request len 64.
  - s_alloc_ready stays low.
  - free(BUF_START+0x600) -> used 2560; the request is accepted next cycle with addr BUF_START+0x600.
- Errors:
  - free(BUF_START) while the head is B -> err_free=1, used and inflight_cnt unchanged.
  - Request len 0 -> err_len pulses once, no descriptor.
- Backpressure and concurrency:
  - m_write_desc_ready low for 10 cycles -> descriptor stable, s_alloc_ready low.
  - An accept and a valid free in the same cycle -> used = old + cost - freed cost, inflight_cnt unchanged.
- Reset with 3 allocations in flight -> used_bytes 0, inflight_cnt 0, valid 0; the next alloc returns BUF_START.
